// File: rtl/bsg_hash_bank_resp_arb.sv
// Round-robin return-path arbiter: picks one tagged bank response per cycle and
// buffers it in a 2-entry FIFO presenting {bank, index, data} to the reverse hash.
module bsg_hash_bank_resp_arb #(
    parameter int banks_p       = 4,
    parameter int index_width_p = 2,
    parameter int data_width_p  = 32,
    localparam int bank_width_lp = (banks_p == 1) ? 1 : $clog2(banks_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [banks_p-1:0]                v_i,
    input  logic [banks_p*index_width_p-1:0]  index_i,
    input  logic [banks_p*data_width_p-1:0]   data_i,
    output logic [banks_p-1:0]                yumi_o,
    output logic                              v_o,
    output logic [bank_width_lp-1:0]          bank_o,
    output logic [index_width_p-1:0]          index_o,
    output logic [data_width_p-1:0]           data_o,
    input  logic                              yumi_i
);

    logic [bank_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [bank_width_lp-1:0] bank_mem_q  [2];
    logic [bank_width_lp-1:0] bank_mem_d  [2];
    logic [index_width_p-1:0] index_mem_q [2];
    logic [index_width_p-1:0] index_mem_d [2];
    logic [data_width_p-1:0]  data_mem_q  [2];
    logic [data_width_p-1:0]  data_mem_d  [2];
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic [1:0]               count_q, count_d;
    logic                     full_q, full_d;

    logic [index_width_p-1:0] index_arr [banks_p];
    logic [data_width_p-1:0]  data_arr  [banks_p];
    logic                     grant_v;
    logic [bank_width_lp-1:0] grant_idx;
    logic                     deq;

    always_comb begin
        for (int b = 0; b < banks_p; b++) begin
            index_arr[b] = index_i[b*index_width_p +: index_width_p];
            data_arr[b]  = data_i[b*data_width_p +: data_width_p];
        end
    end

    // Grant depends only on registered full, so yumi_i never reaches yumi_o.
    always_comb begin
        int cand;
        cand      = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        yumi_o    = '0;
        if (!reset_i && !full_q) begin
            for (int i = 0; i < banks_p; i++) begin
                cand = (int'(rr_ptr_q) + i) % banks_p;
                if (!grant_v && v_i[cand]) begin
                    grant_v   = 1'b1;
                    grant_idx = cand[bank_width_lp-1:0];
                end
            end
        end
        if (grant_v) begin
            yumi_o[grant_idx] = 1'b1;
        end
    end

    assign deq = yumi_i && (count_q != 2'd0);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        bank_mem_d  = bank_mem_q;
        index_mem_d = index_mem_q;
        data_mem_d  = data_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (grant_v) begin
            bank_mem_d[wr_ptr_q]  = grant_idx;
            index_mem_d[wr_ptr_q] = index_arr[grant_idx];
            data_mem_d[wr_ptr_q]  = data_arr[grant_idx];
            wr_ptr_d              = ~wr_ptr_q;
            rr_ptr_d = (int'(grant_idx) == banks_p - 1) ? '0
                                                        : grant_idx + bank_width_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({grant_v, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == 2'd2);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                bank_mem_q[e]  <= '0;
                index_mem_q[e] <= '0;
                data_mem_q[e]  <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            bank_mem_q  <= bank_mem_d;
            index_mem_q <= index_mem_d;
            data_mem_q  <= data_mem_d;
        end
    end

    assign v_o     = (count_q != 2'd0);
    assign bank_o  = bank_mem_q[rd_ptr_q];
    assign index_o = index_mem_q[rd_ptr_q];
    assign data_o  = data_mem_q[rd_ptr_q];

    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
    assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(yumi_o));

endmodule

// File: tb/tb_bsg_hash_bank_resp_arb.sv
// Directed bench for bsg_hash_bank_resp_arb: a 4-bank instance and a 1-bank
// instance sharing clock and reset, checked with immediate assertions.
module tb_bsg_hash_bank_resp_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   v_i;
    logic [7:0]   index_i;
    logic [127:0] data_i;
    logic [3:0]   yumi_o;
    logic         v_o;
    logic [1:0]   bank_o;
    logic [1:0]   index_o;
    logic [31:0]  data_o;
    logic         yumi_i;

    logic         v1_i;
    logic [1:0]   index1_i;
    logic [31:0]  data1_i;
    logic [0:0]   yumi1_o;
    logic         v1_o;
    logic [0:0]   bank1_o;
    logic [1:0]   index1_o;
    logic [31:0]  data1_o;
    logic         yumi1_i;

    int checks = 0;
    int errors = 0;

    bsg_hash_bank_resp_arb #(.banks_p(4), .index_width_p(2), .data_width_p(32)) dut (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .index_i(index_i), .data_i(data_i),
        .yumi_o(yumi_o), .v_o(v_o), .bank_o(bank_o), .index_o(index_o),
        .data_o(data_o), .yumi_i(yumi_i)
    );

    bsg_hash_bank_resp_arb #(.banks_p(1), .index_width_p(2), .data_width_p(32)) dut1 (
        .clk_i(clk), .reset_i(rst), .v_i(v1_i), .index_i(index1_i), .data_i(data1_i),
        .yumi_o(yumi1_o), .v_o(v1_o), .bank_o(bank1_o), .index_o(index1_o),
        .data_o(data1_o), .yumi_i(yumi1_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input int b, input logic [1:0] idx, input logic [31:0] dat);
        index_i[b*2 +: 2]  = idx;
        data_i[b*32 +: 32] = dat;
    endtask

    initial begin
        rst = 1'b1;
        v_i = '0; index_i = '0; data_i = '0; yumi_i = 1'b0;
        v1_i = 1'b0; index1_i = '0; data1_i = '0; yumi1_i = 1'b0;
        next_cycle();

        // Reset held with all banks requesting
        v_i = 4'b1111;
        for (int b = 0; b < 4; b++) set_bank(b, 2'(b), 32'hA000_0000 + 32'(b));
        @(negedge clk);
        check("rst_yumi_o", 64'(yumi_o), 64'h0);
        check("rst_v_o", 64'(v_o), 64'h0);
        check("rst_bank_o", 64'(bank_o), 64'h0);
        check("rst_index_o", 64'(index_o), 64'h0);
        check("rst_data_o", 64'(data_o), 64'h0);
        check("rst_v1_o", 64'(v1_o), 64'h0);
        next_cycle();
        rst = 1'b0;

        // Round-robin sweep from bank 0
        @(negedge clk);
        check("rr0_yumi", 64'(yumi_o), 64'h1);
        check("rr0_v_o", 64'(v_o), 64'h0);
        next_cycle();
        yumi_i = 1'b1;
        @(negedge clk);
        check("rr1_yumi", 64'(yumi_o), 64'h2);
        check("rr1_bank", 64'(bank_o), 64'h0);
        check("rr1_index", 64'(index_o), 64'h0);
        check("rr1_data", 64'(data_o), 64'hA000_0000);
        next_cycle();
        @(negedge clk);
        check("rr2_yumi", 64'(yumi_o), 64'h4);
        check("rr2_bank", 64'(bank_o), 64'h1);
        check("rr2_index", 64'(index_o), 64'h1);
        check("rr2_data", 64'(data_o), 64'hA000_0001);
        next_cycle();
        @(negedge clk);
        check("rr3_yumi", 64'(yumi_o), 64'h8);
        check("rr3_bank", 64'(bank_o), 64'h2);
        next_cycle();
        @(negedge clk);
        check("rr4_yumi", 64'(yumi_o), 64'h1);
        check("rr4_bank", 64'(bank_o), 64'h3);
        next_cycle();
        v_i = 4'b0000;
        @(negedge clk);
        check("rr5_bank", 64'(bank_o), 64'h0);
        check("rr5_v_o", 64'(v_o), 64'h1);
        check("rr5_yumi", 64'(yumi_o), 64'h0);
        next_cycle();
        yumi_i = 1'b0;
        @(negedge clk);
        check("drain_v_o", 64'(v_o), 64'h0);
        next_cycle();

        // Single requester fills the FIFO (rr_ptr is 1 here)
        v_i = 4'b0100;
        set_bank(2, 2'b11, 32'hDEAD_BEEF);
        @(negedge clk);
        check("fill0_yumi", 64'(yumi_o), 64'h4);
        next_cycle();
        @(negedge clk);
        check("fill1_yumi", 64'(yumi_o), 64'h4);
        check("fill1_v_o", 64'(v_o), 64'h1);
        next_cycle();
        @(negedge clk);
        check("full_yumi", 64'(yumi_o), 64'h0);
        check("full_v_o", 64'(v_o), 64'h1);
        check("full_bank", 64'(bank_o), 64'h2);
        check("full_index", 64'(index_o), 64'h3);
        check("full_data", 64'(data_o), 64'hDEAD_BEEF);

        // Pop while full: no grant this cycle, grant resumes next
        yumi_i = 1'b1;
        #1;
        check("full_pop_yumi", 64'(yumi_o), 64'h0);
        next_cycle();
        yumi_i = 1'b0;
        @(negedge clk);
        check("resume_yumi", 64'(yumi_o), 64'h4);
        check("resume_v_o", 64'(v_o), 64'h1);
        next_cycle();
        @(negedge clk);
        check("refull_yumi", 64'(yumi_o), 64'h0);
        next_cycle();
        v_i = 4'b0000;
        yumi_i = 1'b1;
        next_cycle();
        next_cycle();
        yumi_i = 1'b0;
        @(negedge clk);
        check("drain2_v_o", 64'(v_o), 64'h0);
        next_cycle();

        // Sole requester bank 3, one per cycle
        v_i = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            set_bank(3, 2'b01, 32'h3000_0000 + 32'(k));
            yumi_i = (k != 0);
            @(negedge clk);
            check("solo_yumi", 64'(yumi_o), 64'h8);
            if (k != 0) begin
                check("solo_v_o", 64'(v_o), 64'h1);
                check("solo_data", 64'(data_o), 64'h3000_0000 + 64'(k - 1));
            end
            next_cycle();
        end

        // rr_ptr must now be 0: banks 1 and 2 requesting picks 1 first
        v_i = 4'b0110;
        set_bank(1, 2'b10, 32'h1111_1111);
        set_bank(2, 2'b01, 32'h2222_2222);
        yumi_i = 1'b1;
        @(negedge clk);
        check("after_solo_yumi", 64'(yumi_o), 64'h2);
        check("after_solo_data", 64'(data_o), 64'h3000_0004);
        next_cycle();
        yumi_i = 1'b0;
        @(negedge clk);
        check("fill_b2_yumi", 64'(yumi_o), 64'h4);
        check("fill_b2_bank", 64'(bank_o), 64'h1);
        next_cycle();
        @(negedge clk);
        check("held2_yumi", 64'(yumi_o), 64'h0);
        check("held2_v_o", 64'(v_o), 64'h1);

        // Asynchronous reset mid-stream with two entries held (rr_ptr is 3)
        rst = 1'b1;
        #1;
        check("async_v_o", 64'(v_o), 64'h0);
        check("async_yumi", 64'(yumi_o), 64'h0);
        check("async_bank", 64'(bank_o), 64'h0);
        next_cycle();
        rst = 1'b0;
        v_i = 4'b1010;
        @(negedge clk);
        check("post_rst_yumi", 64'(yumi_o), 64'h2);
        check("post_rst_v_o", 64'(v_o), 64'h0);
        next_cycle();
        v_i = 4'b0000;
        @(negedge clk);
        check("post_rst_bank", 64'(bank_o), 64'h1);
        check("post_rst_index", 64'(index_o), 64'h2);

        // Single-bank instance
        next_cycle();
        v1_i = 1'b1; index1_i = 2'b10; data1_i = 32'hCAFE_0001;
        @(negedge clk);
        check("b1_yumi0", 64'(yumi1_o), 64'h1);
        next_cycle();
        index1_i = 2'b01; data1_i = 32'hCAFE_0002; yumi1_i = 1'b1;
        @(negedge clk);
        check("b1_yumi1", 64'(yumi1_o), 64'h1);
        check("b1_v0", 64'(v1_o), 64'h1);
        check("b1_bank0", 64'(bank1_o), 64'h0);
        check("b1_index0", 64'(index1_o), 64'h2);
        check("b1_data0", 64'(data1_o), 64'hCAFE_0001);
        next_cycle();
        v1_i = 1'b0;
        @(negedge clk);
        check("b1_v1", 64'(v1_o), 64'h1);
        check("b1_bank1", 64'(bank1_o), 64'h0);
        check("b1_index1", 64'(index1_o), 64'h1);
        check("b1_data1", 64'(data1_o), 64'hCAFE_0002);
        next_cycle();
        yumi1_i = 1'b0;
        @(negedge clk);
        check("b1_empty", 64'(v1_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
